// File: rtl/sweep_sequencer_if.sv
// Host and sweep-side signal bundle for sweep_sequencer.
// The master modport is the host/sweep side; the slave modport is the sequencer.
interface sweep_sequencer_if #(
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
);
    logic                    cfg_load_in;
    logic signed [15:0]      cfg_min_in;
    logic signed [15:0]      cfg_max_in;
    logic        [32:0]      cfg_step_in;
    logic        [CNT_W-1:0] cfg_periods_in;
    logic                    start_in;
    logic                    stop_in;
    logic                    abort_in;
    logic signed [SIG_W-1:0] sweep_sig_in;

    logic                    sweep_on_out;
    logic signed [15:0]      minval_out;
    logic signed [15:0]      maxval_out;
    logic        [32:0]      stepsize_out;
    logic                    busy_out;
    logic                    done_out;
    logic                    cfg_err_out;
    logic                    cfg_pending_out;
    logic        [CNT_W-1:0] period_count_out;
    logic        [1:0]       state_out;

    modport master (
        output cfg_load_in, cfg_min_in, cfg_max_in, cfg_step_in, cfg_periods_in,
               start_in, stop_in, abort_in, sweep_sig_in,
        input  sweep_on_out, minval_out, maxval_out, stepsize_out, busy_out,
               done_out, cfg_err_out, cfg_pending_out, period_count_out, state_out
    );

    modport slave (
        input  cfg_load_in, cfg_min_in, cfg_max_in, cfg_step_in, cfg_periods_in,
               start_in, stop_in, abort_in, sweep_sig_in,
        output sweep_on_out, minval_out, maxval_out, stepsize_out, busy_out,
               done_out, cfg_err_out, cfg_pending_out, period_count_out, state_out
    );
endinterface

// File: rtl/sweep_sequencer.sv
// Sequencer for the triangle sweep: validates/stages config, applies it glitch-free
// (idle or at top turnaround), and runs a counted or continuous number of periods.
module sweep_sequencer #(
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    sweep_sequencer_if.slave bus
);
    // state    | meaning
    // IDLE     | sweep off; a pending config is applied on the next cycle
    // RUN      | sweep on; each bottom turnaround counts one period
    // STOPPING | sweep on; the next bottom turnaround ends the run
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    on_q, on_d;
    logic                    done_q, done_d;
    logic signed [15:0]      sh_min_q, sh_max_q, act_min_q, act_max_q;
    logic        [32:0]      sh_step_q, act_step_q;
    logic                    pending_q, pending_d;
    logic                    err_q;
    logic signed [SIG_W-1:0] prev_q;
    logic                    dir_down_q;
    logic        [CNT_W-1:0] count_q, target_q, count_inc;
    logic                    cfg_ok, active_ok, running, start_ok;
    logic                    top_ev, bot_ev, reach, apply, load_ok;

    assign cfg_ok    = ($signed(bus.cfg_min_in) < $signed(bus.cfg_max_in)) && (bus.cfg_step_in != '0);
    assign load_ok   = bus.cfg_load_in && cfg_ok;
    assign active_ok = (act_min_q < act_max_q) && (act_step_q != '0);
    assign running   = (state_q != ST_IDLE);
    assign start_ok  = bus.start_in && active_ok;
    assign top_ev    = running && !dir_down_q && ($signed(bus.sweep_sig_in) < prev_q);
    assign bot_ev    = running && dir_down_q && ($signed(bus.sweep_sig_in) > prev_q);
    assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    assign reach     = (target_q != '0) && (count_inc == target_q);
    // pending_q is the pre-load value, so a load coinciding with a top waits for the next one
    assign apply     = pending_q && (!running || top_ev);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            on_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort_in)         state_d = ST_IDLE;
                else if (bot_ev && reach) state_d = ST_IDLE;
                else if (bus.stop_in)     state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (bus.abort_in || bot_ev) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        on_d   = (state_d != ST_IDLE);
        done_d = running && (state_d == ST_IDLE) && !bus.abort_in;
    end

    always_comb begin
        pending_d = pending_q;
        if (apply)   pending_d = 1'b0;
        if (load_ok) pending_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_q      <= 1'b0;
            pending_q  <= 1'b0;
            sh_min_q   <= '0;
            sh_max_q   <= '0;
            sh_step_q  <= '0;
            act_min_q  <= '0;
            act_max_q  <= '0;
            act_step_q <= '0;
            prev_q     <= '0;
            dir_down_q <= 1'b0;
            count_q    <= '0;
            target_q   <= '0;
        end else begin
            err_q     <= bus.cfg_load_in && !cfg_ok;
            pending_q <= pending_d;
            if (load_ok) begin
                sh_min_q  <= bus.cfg_min_in;
                sh_max_q  <= bus.cfg_max_in;
                sh_step_q <= bus.cfg_step_in;
            end
            if (apply) begin
                act_min_q  <= sh_min_q;
                act_max_q  <= sh_max_q;
                act_step_q <= sh_step_q;
            end
            if (!running) begin
                if (start_ok) begin
                    count_q    <= '0;
                    target_q   <= bus.cfg_periods_in;
                    prev_q     <= '0;
                    dir_down_q <= 1'b0;
                end
            end else begin
                prev_q <= bus.sweep_sig_in;
                if (top_ev)      dir_down_q <= 1'b1;
                else if (bot_ev) dir_down_q <= 1'b0;
                if (bot_ev && !bus.abort_in) count_q <= count_inc;
            end
        end
    end

    assign bus.sweep_on_out     = on_q;
    assign bus.minval_out       = act_min_q;
    assign bus.maxval_out       = act_max_q;
    assign bus.stepsize_out     = act_step_q;
    assign bus.busy_out         = running;
    assign bus.done_out         = done_q;
    assign bus.cfg_err_out      = err_q;
    assign bus.cfg_pending_out  = pending_q;
    assign bus.period_count_out = count_q;
    assign bus.state_out        = state_q;
endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: a behavioural triangle source stands in for the sweep,
// and each task checks the sequencer's reaction to configuration and run control.
module tb_sweep_sequencer;
    localparam int SIG_W = 16;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sweep_sequencer_if #(.SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();
    sweep_sequencer #(.SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Triangle source: moves g_inc per cycle between g_lo and g_hi, starting from 0 upward.
    bit gen_on    = 1'b0;
    int g_pos     = 0;
    int g_lo      = 0;
    int g_hi      = 0;
    int g_inc     = 1;
    bit g_up      = 1'b1;
    bit g_last_up = 1'b1;

    task automatic gen_start(input int inc, input int lo, input int hi);
        gen_on = 1'b1; g_pos = 0; g_inc = inc; g_lo = lo; g_hi = hi;
        g_up = 1'b1; g_last_up = 1'b1;
    endtask

    // One clock: present the next sample, report whether it is a top/bottom turnaround.
    task automatic tick(output bit top, output bit bot);
        bit mv_up;
        top = 1'b0; bot = 1'b0;
        if (gen_on) begin
            mv_up = g_up;
            if (g_up) begin
                g_pos += g_inc;
                if (g_pos >= g_hi) begin g_pos = g_hi; g_up = 1'b0; end
            end else begin
                g_pos -= g_inc;
                if (g_pos <= g_lo) begin g_pos = g_lo; g_up = 1'b1; end
            end
            top = g_last_up && !mv_up;
            bot = !g_last_up && mv_up;
            g_last_up = mv_up;
        end else begin
            g_pos = 0;
        end
        bus.sweep_sig_in = SIG_W'(g_pos);
        @(posedge clk);
        @(negedge clk);
        bus.cfg_load_in = 1'b0; bus.start_in = 1'b0;
        bus.stop_in     = 1'b0; bus.abort_in = 1'b0;
    endtask

    task automatic set_cfg(input int mn, input int mx, input logic [32:0] st, input int per);
        bus.cfg_min_in     = 16'(mn);
        bus.cfg_max_in     = 16'(mx);
        bus.cfg_step_in    = st;
        bus.cfg_periods_in = CNT_W'(per);
        bus.cfg_load_in    = 1'b1;
    endtask

    task automatic test_reset();
        bit t, b;
        bus.cfg_load_in = 0; bus.cfg_min_in = 0; bus.cfg_max_in = 0; bus.cfg_step_in = 0;
        bus.cfg_periods_in = 0; bus.start_in = 0; bus.stop_in = 0; bus.abort_in = 0;
        bus.sweep_sig_in = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.sweep_on_out, bus.busy_out, bus.done_out, bus.cfg_err_out, bus.cfg_pending_out,
             bus.state_out, bus.period_count_out, bus.minval_out, bus.maxval_out, bus.stepsize_out} !== '0)
            $display("FAIL reset_outputs: got on=%b busy=%b state=%0d min=%0d max=%0d step=%h want all zero",
                     bus.sweep_on_out, bus.busy_out, bus.state_out, bus.minval_out, bus.maxval_out, bus.stepsize_out);
        else n_pass++;
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b1; tick(t, b);
        n_total++;
        if ({bus.busy_out, bus.sweep_on_out, bus.state_out} !== 4'b0)
            $display("FAIL start_without_cfg: got busy=%b on=%b state=%0d want 0 0 0",
                     bus.busy_out, bus.sweep_on_out, bus.state_out);
        else n_pass++;
    endtask

    task automatic test_cfg_reject();
        bit t, b;
        set_cfg(100, 100, 33'h10000, 1); tick(t, b);
        n_total++;
        if ({bus.cfg_err_out, bus.cfg_pending_out} !== 2'b10)
            $display("FAIL reject_equal: got err=%b pending=%b want 1 0", bus.cfg_err_out, bus.cfg_pending_out);
        else n_pass++;
        tick(t, b);
        n_total++;
        if (bus.cfg_err_out !== 1'b0)
            $display("FAIL err_pulse_width: got err=%b want 0", bus.cfg_err_out);
        else n_pass++;
        set_cfg(-5, 5, 33'h0, 1); tick(t, b);
        n_total++;
        if ({bus.cfg_err_out, bus.cfg_pending_out} !== 2'b10)
            $display("FAIL reject_zero_step: got err=%b pending=%b want 1 0", bus.cfg_err_out, bus.cfg_pending_out);
        else n_pass++;
        tick(t, b);
        n_total++;
        if ({bus.minval_out, bus.maxval_out, bus.stepsize_out} !== 65'b0)
            $display("FAIL reject_active_unchanged: got min=%0d max=%0d step=%h want 0 0 0",
                     bus.minval_out, bus.maxval_out, bus.stepsize_out);
        else n_pass++;
        bus.start_in = 1'b1; tick(t, b);
        n_total++;
        if ({bus.busy_out, bus.sweep_on_out} !== 2'b00)
            $display("FAIL start_after_reject: got busy=%b on=%b want 0 0", bus.busy_out, bus.sweep_on_out);
        else n_pass++;
    endtask

    task automatic test_basic_run();
        bit t, b;
        int bots = 0;
        int bad = 0;
        set_cfg(-400, 400, 33'h10000, 2); tick(t, b);
        n_total++;
        if ({bus.cfg_pending_out, bus.minval_out} !== {1'b1, 16'sd0})
            $display("FAIL idle_pending: got pending=%b min=%0d want 1 0", bus.cfg_pending_out, bus.minval_out);
        else n_pass++;
        tick(t, b);
        n_total++;
        if ({bus.cfg_pending_out, bus.minval_out, bus.maxval_out, bus.stepsize_out} !==
            {1'b0, 16'(-400), 16'sd400, 33'h10000})
            $display("FAIL idle_apply: got pending=%b min=%0d max=%0d step=%h want 0 -400 400 10000",
                     bus.cfg_pending_out, bus.minval_out, bus.maxval_out, bus.stepsize_out);
        else n_pass++;
        bus.start_in = 1'b1; tick(t, b);
        n_total++;
        if ({bus.busy_out, bus.sweep_on_out, bus.state_out, bus.period_count_out} !== {2'b11, 2'd1, 16'd0})
            $display("FAIL start_run: got busy=%b on=%b state=%0d count=%0d want 1 1 1 0",
                     bus.busy_out, bus.sweep_on_out, bus.state_out, bus.period_count_out);
        else n_pass++;
        gen_start(1, -400, 400);
        for (int c = 0; c < 5000 && bots < 2; c++) begin
            tick(t, b);
            if (b) begin
                bots++;
                if (bus.period_count_out !== CNT_W'(bots)) bad++;
            end else if (bus.done_out !== 1'b0 || bus.sweep_on_out !== 1'b1) bad++;
        end
        gen_on = 1'b0;
        n_total++;
        if (bots != 2 || bad != 0)
            $display("FAIL basic_progress: got bottoms=%0d errors=%0d want 2 0", bots, bad);
        else n_pass++;
        n_total++;
        if ({bus.done_out, bus.sweep_on_out, bus.busy_out, bus.state_out, bus.period_count_out} !==
            {3'b100, 2'd0, 16'd2})
            $display("FAIL basic_done: got done=%b on=%b busy=%b state=%0d count=%0d want 1 0 0 0 2",
                     bus.done_out, bus.sweep_on_out, bus.busy_out, bus.state_out, bus.period_count_out);
        else n_pass++;
        tick(t, b);
        n_total++;
        if ({bus.done_out, bus.period_count_out} !== {1'b0, 16'd2})
            $display("FAIL basic_done_once: got done=%b count=%0d want 0 2", bus.done_out, bus.period_count_out);
        else n_pass++;
    endtask

    task automatic test_random_runs();
        bit t, b, fin;
        int lo, hi, inc, per, bots, bad;
        logic [32:0] st;
        for (int r = 0; r < 3; r++) begin
            lo  = -int'($urandom_range(600, 50));
            hi  = int'($urandom_range(600, 50));
            inc = int'($urandom_range(40, 4));
            per = int'($urandom_range(3, 1));
            st  = {inc[16:0], 16'($urandom)};
            set_cfg(hi, lo, st, per); tick(t, b);
            n_total++;
            if ({bus.cfg_err_out, bus.cfg_pending_out} !== 2'b10)
                $display("FAIL rand_reject_inverted: got err=%b pending=%b want 1 0",
                         bus.cfg_err_out, bus.cfg_pending_out);
            else n_pass++;
            set_cfg(lo, hi, st, per); tick(t, b); tick(t, b);
            n_total++;
            if ({bus.minval_out, bus.maxval_out, bus.stepsize_out, bus.cfg_pending_out} !==
                {16'(lo), 16'(hi), st, 1'b0})
                $display("FAIL rand_apply: got min=%0d max=%0d step=%h want %0d %0d %h",
                         bus.minval_out, bus.maxval_out, bus.stepsize_out, lo, hi, st);
            else n_pass++;
            bus.start_in = 1'b1; tick(t, b);
            bus.cfg_periods_in = CNT_W'($urandom_range(7, 0));
            gen_start(inc, lo, hi);
            bots = 0; bad = 0; fin = 1'b0;
            for (int c = 0; c < 20000 && !fin; c++) begin
                tick(t, b);
                if (b) begin
                    bots++;
                    if (bus.period_count_out !== CNT_W'(bots)) bad++;
                end
                if (bots == per) fin = 1'b1;
                else if (bus.done_out !== 1'b0 || bus.sweep_on_out !== 1'b1) bad++;
            end
            gen_on = 1'b0;
            n_total++;
            if (!fin || bad != 0)
                $display("FAIL rand_run_progress: got bottoms=%0d errors=%0d want %0d 0", bots, bad, per);
            else n_pass++;
            n_total++;
            if ({bus.done_out, bus.sweep_on_out, bus.busy_out, bus.period_count_out} !== {3'b100, CNT_W'(per)})
                $display("FAIL rand_run_done: got done=%b on=%b busy=%b count=%0d want 1 0 0 %0d",
                         bus.done_out, bus.sweep_on_out, bus.busy_out, bus.period_count_out, per);
            else n_pass++;
        end
    endtask

    task automatic test_cont_apply_stop();
        bit t, b, found;
        int bots = 0;
        int bad = 0;
        set_cfg(-400, 400, 33'h80000, 0); tick(t, b); tick(t, b);
        bus.start_in = 1'b1; tick(t, b);
        gen_start(8, -400, 400);
        repeat (10) tick(t, b);
        set_cfg(-400, 200, 33'h80000, 0); tick(t, b);
        n_total++;
        if ({bus.cfg_pending_out, bus.maxval_out} !== {1'b1, 16'sd400})
            $display("FAIL pending_mid_rise: got pending=%b max=%0d want 1 400", bus.cfg_pending_out, bus.maxval_out);
        else n_pass++;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            tick(t, b);
            if (t) found = 1'b1;
            else if (bus.cfg_pending_out !== 1'b1 || bus.maxval_out !== 16'sd400) bad++;
        end
        n_total++;
        if (!found || bad != 0)
            $display("FAIL hold_until_top: got top_seen=%b early_changes=%0d want 1 0", found, bad);
        else n_pass++;
        n_total++;
        if ({bus.cfg_pending_out, bus.maxval_out} !== {1'b0, 16'sd200})
            $display("FAIL apply_at_top: got pending=%b max=%0d want 0 200", bus.cfg_pending_out, bus.maxval_out);
        else n_pass++;
        g_hi = 200;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            if (!g_up && g_last_up) found = 1'b1;
            else begin tick(t, b); if (b) bots++; end
        end
        set_cfg(-400, 300, 33'h80000, 0); tick(t, b);
        n_total++;
        if (!t || {bus.cfg_pending_out, bus.maxval_out} !== {1'b1, 16'sd200})
            $display("FAIL load_at_top_deferred: got top=%b pending=%b max=%0d want 1 1 200",
                     t, bus.cfg_pending_out, bus.maxval_out);
        else n_pass++;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            tick(t, b);
            if (b) bots++;
            if (t) found = 1'b1;
        end
        n_total++;
        if (!found || {bus.cfg_pending_out, bus.maxval_out, bus.period_count_out} !== {1'b0, 16'sd300, CNT_W'(bots)})
            $display("FAIL apply_next_top: got pending=%b max=%0d count=%0d want 0 300 %0d",
                     bus.cfg_pending_out, bus.maxval_out, bus.period_count_out, bots);
        else n_pass++;
        g_hi = 300;
        bus.stop_in = 1'b1; tick(t, b);
        n_total++;
        if ({bus.state_out, bus.busy_out, bus.sweep_on_out} !== {2'd2, 2'b11})
            $display("FAIL stopping_state: got state=%0d busy=%b on=%b want 2 1 1",
                     bus.state_out, bus.busy_out, bus.sweep_on_out);
        else n_pass++;
        found = 1'b0; bad = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            tick(t, b);
            if (b) found = 1'b1;
            else if (bus.state_out !== 2'd2 || bus.done_out !== 1'b0) bad++;
        end
        gen_on = 1'b0;
        n_total++;
        if (!found || bad != 0 ||
            {bus.state_out, bus.done_out, bus.sweep_on_out, bus.period_count_out} !== {2'd0, 2'b10, CNT_W'(bots + 1)})
            $display("FAIL stop_at_bottom: got state=%0d done=%b on=%b count=%0d errors=%0d want 0 1 0 %0d 0",
                     bus.state_out, bus.done_out, bus.sweep_on_out, bus.period_count_out, bad, bots + 1);
        else n_pass++;
        tick(t, b);
        n_total++;
        if ({bus.done_out, bus.period_count_out} !== {1'b0, CNT_W'(bots + 1)})
            $display("FAIL stop_done_once: got done=%b count=%0d want 0 %0d", bus.done_out, bus.period_count_out, bots + 1);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit t, b;
        bus.cfg_periods_in = '0;
        bus.start_in = 1'b1; tick(t, b);
        gen_start(8, -400, 300);
        n_total++;
        if ({bus.busy_out, bus.sweep_on_out, bus.period_count_out} !== {2'b11, 16'd0})
            $display("FAIL abort_run_start: got busy=%b on=%b count=%0d want 1 1 0",
                     bus.busy_out, bus.sweep_on_out, bus.period_count_out);
        else n_pass++;
        repeat ($urandom_range(30, 2)) tick(t, b);
        set_cfg(-400, 350, 33'h80000, 0); tick(t, b);
        bus.abort_in = 1'b1; bus.stop_in = 1'b1; tick(t, b);
        gen_on = 1'b0;
        n_total++;
        if ({bus.state_out, bus.sweep_on_out, bus.busy_out, bus.done_out, bus.cfg_pending_out, bus.maxval_out} !==
            {2'd0, 4'b0001, 16'sd300})
            $display("FAIL abort_with_stop: got state=%0d on=%b busy=%b done=%b pending=%b max=%0d want 0 0 0 0 1 300",
                     bus.state_out, bus.sweep_on_out, bus.busy_out, bus.done_out, bus.cfg_pending_out, bus.maxval_out);
        else n_pass++;
        tick(t, b);
        n_total++;
        if ({bus.maxval_out, bus.cfg_pending_out, bus.done_out, bus.state_out} !== {16'sd350, 2'b00, 2'd0})
            $display("FAIL pending_after_abort: got max=%0d pending=%b done=%b state=%0d want 350 0 0 0",
                     bus.maxval_out, bus.cfg_pending_out, bus.done_out, bus.state_out);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        bit t, b;
        set_cfg(-300, 300, 33'h40000, 0); tick(t, b); tick(t, b);
        bus.start_in = 1'b1; tick(t, b);
        gen_start(4, -300, 300);
        repeat (7) tick(t, b);
        #3 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.sweep_on_out, bus.busy_out, bus.done_out, bus.cfg_err_out, bus.cfg_pending_out,
             bus.state_out, bus.period_count_out, bus.minval_out, bus.maxval_out, bus.stepsize_out} !== '0)
            $display("FAIL midrun_reset: got on=%b busy=%b done=%b state=%0d min=%0d max=%0d want all zero",
                     bus.sweep_on_out, bus.busy_out, bus.done_out, bus.state_out, bus.minval_out, bus.maxval_out);
        else n_pass++;
        gen_on = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b1; tick(t, b);
        n_total++;
        if ({bus.busy_out, bus.sweep_on_out, bus.state_out, bus.done_out} !== 5'b0)
            $display("FAIL start_after_reset: got busy=%b on=%b state=%0d done=%b want 0 0 0 0",
                     bus.busy_out, bus.sweep_on_out, bus.state_out, bus.done_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cfg_reject();
        test_basic_run();
        test_random_runs();
        test_cont_apply_stop();
        test_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
